// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_pkg
//  Purpose  : Shared constants and FSM state type for the RSA modular
//             exponentiation block and its serial modular multiplier.
//  Contents : WIDTH, LATENCY, MM_CYCLES, state_t
//  Revision : 1.0 - initial release
// ============================================================================
package rsa_pkg;

  localparam int WIDTH     = 32;
  // Cycles from the start cycle of a multiply through its done cycle.
  localparam int MM_CYCLES = 33;
  // Accept edge to out_valid for valid operands: CHECK, 64 multiplies, DONE.
  localparam int LATENCY   = 2 + 2 * WIDTH * MM_CYCLES;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SQR   = 3'd2,
    MUL   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage : rsa_pkg
`default_nettype wire

// File: rtl/rsa_modexp_modmul.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_modmul
//  Purpose  : Serial shift-add modular multiplier, r = a*b mod n.
//             One start cycle latches the operands, then 32 iteration cycles
//             process a from MSB to LSB. done is high in the last iteration
//             cycle, during which r already shows the final product; after
//             that r holds the product until the next start.
//             Requires b < n and n >= 1 for a fully reduced result.
//  Ports    : clk, rst_n  - clock, asynchronous active-low reset
//             start       - begin a multiply (ignored while a multiply runs)
//             a, b, n     - multiplicand, multiplier, modulus
//             r           - result
//             done        - final iteration cycle
//  Revision : 1.0 - initial release
// ============================================================================
module rsa_modmul
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r,
  output logic             done
);

  localparam logic [4:0] LAST_ITER = 5'(MM_CYCLES - 2);

  logic             active;
  logic [4:0]       iterCnt;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] nReg;
  logic [WIDTH-1:0] accReg;

  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] red1;
  logic [WIDTH+1:0] red2;
  logic [WIDTH+1:0] nWide;
  logic [WIDTH-1:0] nextAcc;

  // With acc < n and b < n the sum stays below 3n, so two conditional
  // subtractions always bring it back into [0, n). 34 bits hold 3n.
  always_comb begin
    nWide   = {2'b00, nReg};
    sum     = {1'b0, accReg, 1'b0} + {2'b00, (aReg[WIDTH-1] ? bReg : '0)};
    red1    = (sum  >= nWide) ? (sum  - nWide) : sum;
    red2    = (red1 >= nWide) ? (red1 - nWide) : red1;
    nextAcc = red2[WIDTH-1:0];
  end

  assign done = active && (iterCnt == LAST_ITER);
  assign r    = done ? nextAcc : accReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      iterCnt <= '0;
      aReg    <= '0;
      bReg    <= '0;
      nReg    <= '0;
      accReg  <= '0;
    end else if (!active) begin
      if (start) begin
        active  <= 1'b1;
        iterCnt <= '0;
        aReg    <= a;
        bReg    <= b;
        nReg    <= n;
        accReg  <= '0;
      end
    end else begin
      accReg  <= nextAcc;
      aReg    <= {aReg[WIDTH-2:0], 1'b0};
      iterCnt <= iterCnt + 5'd1;
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule : rsa_modmul
`default_nettype wire

// File: rtl/rsa_modexp.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_modexp
//  Purpose  : Constant-time RSA decryption m = c^d mod n, left-to-right
//             binary exponentiation over all 32 exponent bits. Every bit
//             costs one square and one multiply regardless of its value.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             in_valid, in_ready  - operand handshake (n, d, c)
//             m, err              - result and invalid-operand flag
//             out_valid,out_ready - result handshake
//             busy                - high whenever not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module rsa_modexp
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] m,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_t           state;
  state_t           stateNext;

  logic [WIDTH-1:0] nReg;
  logic [WIDTH-1:0] dReg;
  logic [WIDTH-1:0] cReg;
  logic [WIDTH-1:0] acc;
  logic [4:0]       bitIdx;
  logic             launched;
  logic [WIDTH-1:0] mReg;
  logic             errReg;
  logic             outValid;

  logic             badOperands;
  logic             mmStart;
  logic [WIDTH-1:0] mmB;
  logic [WIDTH-1:0] mmR;
  logic             mmDone;
  logic             curBit;

  assign badOperands = (nReg < 32'd2) || (cReg >= nReg);
  assign curBit      = dReg[bitIdx];

  // Each SQR/MUL state issues exactly one start in its first cycle; the
  // multiplier is idle then because its done edge is also our state change.
  assign mmStart = ((state == SQR) || (state == MUL)) && !launched;
  assign mmB     = (state == MUL) ? cReg : acc;

  rsa_modmul u_modmul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mmStart),
    .a     (acc),
    .b     (mmB),
    .n     (nReg),
    .r     (mmR),
    .done  (mmDone)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (in_valid) stateNext = CHECK;
      CHECK:   stateNext = badOperands ? DONE : SQR;
      SQR:     if (mmDone) stateNext = MUL;
      MUL:     if (mmDone) stateNext = (bitIdx == 5'd0) ? DONE : SQR;
      DONE:    if (outValid && out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nReg     <= '0;
      dReg     <= '0;
      cReg     <= '0;
      acc      <= '0;
      bitIdx   <= '0;
      launched <= 1'b0;
      mReg     <= '0;
      errReg   <= 1'b0;
      outValid <= 1'b0;
    end else begin
      if (mmStart) begin
        launched <= 1'b1;
      end else if (mmDone) begin
        launched <= 1'b0;
      end

      // out_valid trails DONE entry by one cycle and drops on the handshake.
      outValid <= (state == DONE) && !(outValid && out_ready);

      case (state)
        IDLE: begin
          if (in_valid) begin
            nReg   <= n;
            dReg   <= d;
            cReg   <= c;
            bitIdx <= 5'(WIDTH - 1);
            errReg <= 1'b0;
          end
        end
        CHECK: begin
          if (badOperands) begin
            errReg <= 1'b1;
            mReg   <= '0;
          end else begin
            acc <= {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        SQR: begin
          if (mmDone) begin
            acc <= mmR;
          end
        end
        MUL: begin
          if (mmDone) begin
            // The product is always computed; only its use depends on d.
            if (curBit) begin
              acc <= mmR;
            end
            if (bitIdx == 5'd0) begin
              mReg <= curBit ? mmR : acc;
            end else begin
              bitIdx <= bitIdx - 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = outValid;
  assign m         = mReg;
  assign err       = errReg;

endmodule : rsa_modexp
`default_nettype wire
